// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-latch stall/flush/PC-enable generation with load-use
// bubbling, redirect flushing, sticky halt and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned NLATCH     = 4,
  parameter int unsigned JMP_LAT    = 1,
  parameter int unsigned BR_LAT     = 2,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              dhit,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic              load_use,
  input  logic              halt,
  output logic [NLATCH-1:0] latch_en,
  output logic [NLATCH-1:0] latch_flush,
  output logic              pc_en,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;

  localparam logic [3:0]        LU_INIT  = 4'(LU_BUBBLES - 1);
  localparam logic [NLATCH-1:0] ALL_MASK = '1;
  localparam logic [NLATCH-1:0] IFID     = NLATCH'(1);
  localparam logic [NLATCH-1:0] BIT1     = NLATCH'(2);
  localparam logic [NLATCH-1:0] LAST     = NLATCH'(1) << (NLATCH - 1);
  localparam logic [NLATCH-1:0] JMP_MASK = NLATCH'((64'd1 << JMP_LAT) - 64'd1);
  localparam logic [NLATCH-1:0] BR_MASK  = NLATCH'((64'd1 << BR_LAT) - 64'd1);

  state_t     state, state_n;
  logic [3:0] bub, bub_n;
  logic       halted_n;
  logic       stall_inc;
  logic       flush_ev;
  logic       dwait;

  // Priority-ordered control decode and next-state selection.
  always_comb begin
    state_n     = state;
    bub_n       = bub;
    halted_n    = halted;
    stall_inc   = 1'b0;
    flush_ev    = 1'b0;
    latch_en    = ALL_MASK;
    latch_flush = '0;
    pc_en       = 1'b1;
    dwait       = (dmemREN | dmemWEN) & ~dhit;

    if (!nRST) begin
      latch_flush = ALL_MASK;
      pc_en       = 1'b0;
    end else if (state == HALT) begin
      latch_en = '0;
      pc_en    = 1'b0;
    end else begin
      if (dwait) begin
        // Freeze everything; squash MEM/WB so the stalled op is not written back twice.
        pc_en       = 1'b0;
        latch_en    = LAST;
        latch_flush = LAST;
      end else if (state == BUBBLE || load_use) begin
        pc_en       = 1'b0;
        latch_en    = ALL_MASK & ~IFID;
        latch_flush = BIT1;
        if (state == RUN) begin
          bub_n   = LU_INIT;
          state_n = (LU_INIT != 4'd0) ? BUBBLE : RUN;
        end else begin
          bub_n   = bub - 4'd1;
          state_n = (bub == 4'd1) ? RUN : BUBBLE;
        end
      end else if (branch_taken) begin
        latch_flush = BR_MASK;
        flush_ev    = 1'b1;
      end else if (jump) begin
        latch_flush = JMP_MASK;
        flush_ev    = 1'b1;
      end else if (!ihit) begin
        pc_en       = 1'b0;
        latch_flush = IFID;
      end

      if (halt) begin
        state_n  = HALT;
        bub_n    = 4'd0;
        halted_n = 1'b1;
      end
      stall_inc = ~pc_en;
    end
  end

  // State, halt flag and saturating counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      bub       <= 4'd0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_n;
      bub    <= bub_n;
      halted <= halted_n;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus corner-case sequences.
module tb_pipeline_ctrl;

  localparam int unsigned NLATCH = 4;
  localparam int unsigned CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ihit, dmemREN, dmemWEN, dhit, jump, branch_taken, load_use, halt;
  logic [NLATCH-1:0] latch_en, latch_flush;
  logic              pc_en, halted;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(
    .NLATCH(NLATCH), .JMP_LAT(1), .BR_LAT(2), .LU_BUBBLES(3), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .jump(jump), .branch_taken(branch_taken), .load_use(load_use),
    .halt(halt), .latch_en(latch_en), .latch_flush(latch_flush), .pc_en(pc_en),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // in = {ihit, dmemREN, dmemWEN, dhit, jump, branch_taken, load_use, halt}
  typedef struct {
    logic [7:0] in;
    logic [3:0] en;
    logic [3:0] fl;
    logic       pc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic [7:0] in, logic [3:0] en, logic [3:0] fl, logic pc);
    vec_t v;
    v.in = in; v.en = en; v.fl = fl; v.pc = pc;
    return v;
  endfunction

  task automatic apply(input logic [7:0] v);
    {ihit, dmemREN, dmemWEN, dhit, jump, branch_taken, load_use, halt} = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_comb(input string name, input logic [3:0] en, input logic [3:0] fl, input logic pc);
    chk({name, ".latch_en"}, 32'(latch_en), 32'(en));
    chk({name, ".latch_flush"}, 32'(latch_flush), 32'(fl));
    chk({name, ".pc_en"}, 32'(pc_en), 32'(pc));
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(8'h80, 4'hF, 4'h0, 1'b1);
    vecs[1]  = mk(8'h80, 4'hF, 4'h0, 1'b1);
    vecs[2]  = mk(8'h80, 4'hF, 4'h0, 1'b1);
    vecs[3]  = mk(8'hC0, 4'h8, 4'h8, 1'b0);
    vecs[4]  = mk(8'hC0, 4'h8, 4'h8, 1'b0);
    vecs[5]  = mk(8'hC0, 4'h8, 4'h8, 1'b0);
    vecs[6]  = mk(8'hD0, 4'hF, 4'h0, 1'b1);
    vecs[7]  = mk(8'hA0, 4'h8, 4'h8, 1'b0);
    vecs[8]  = mk(8'h82, 4'hE, 4'h2, 1'b0);
    vecs[9]  = mk(8'h80, 4'hE, 4'h2, 1'b0);
    vecs[10] = mk(8'hC0, 4'h8, 4'h8, 1'b0);
    vecs[11] = mk(8'h80, 4'hE, 4'h2, 1'b0);
    vecs[12] = mk(8'h80, 4'hF, 4'h0, 1'b1);
    vecs[13] = mk(8'hC2, 4'h8, 4'h8, 1'b0);
    vecs[14] = mk(8'h8C, 4'hF, 4'h3, 1'b1);
    vecs[15] = mk(8'h88, 4'hF, 4'h1, 1'b1);
    vecs[16] = mk(8'h84, 4'hF, 4'h3, 1'b1);
    vecs[17] = mk(8'hC8, 4'h8, 4'h8, 1'b0);
    vecs[18] = mk(8'h00, 4'hF, 4'h1, 1'b0);
    vecs[19] = mk(8'h08, 4'hF, 4'h1, 1'b1);
    vecs[20] = mk(8'h86, 4'hE, 4'h2, 1'b0);
    vecs[21] = mk(8'h84, 4'hE, 4'h2, 1'b0);
    vecs[22] = mk(8'h82, 4'hE, 4'h2, 1'b0);
    vecs[23] = mk(8'h80, 4'hF, 4'h0, 1'b1);

    // Reset: forced outputs while nRST low, cleared registers after.
    nRST = 1'b0;
    apply(8'h80);
    @(negedge CLK);
    chk_comb("reset", 4'hF, 4'hF, 1'b0);
    @(posedge CLK); #1;
    chk("reset.halted", 32'(halted), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset.flush_cnt", 32'(flush_cnt), 32'd0);
    nRST = 1'b1;

    // Vector table from RUN.
    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].in);
      @(negedge CLK);
      chk_comb($sformatf("vec%0d", i), vecs[i].en, vecs[i].fl, vecs[i].pc);
      @(posedge CLK); #1;
    end
    chk("table.stall_cnt", 32'(stall_cnt), 32'd14);
    chk("table.flush_cnt", 32'(flush_cnt), 32'd4);
    chk("table.halted", 32'(halted), 32'd0);

    // Halt: halt cycle itself still normal, then frozen until reset.
    do_reset();
    apply(8'h81);
    @(negedge CLK);
    chk_comb("halt_cycle", 4'hF, 4'h0, 1'b1);
    @(posedge CLK); #1;
    chk("halt.halted", 32'(halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      apply(8'($urandom));
      @(negedge CLK);
      chk_comb($sformatf("halted%0d", i), 4'h0, 4'h0, 1'b0);
      @(posedge CLK); #1;
      chk($sformatf("halted%0d.flag", i), 32'(halted), 32'd1);
      chk($sformatf("halted%0d.stall_cnt", i), 32'(stall_cnt), 32'd0);
      chk($sformatf("halted%0d.flush_cnt", i), 32'(flush_cnt), 32'd0);
    end
    nRST = 1'b0;
    apply(8'h80);
    @(negedge CLK);
    chk_comb("halt_reset", 4'hF, 4'hF, 1'b0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("unhalt.halted", 32'(halted), 32'd0);
    @(negedge CLK);
    chk_comb("unhalt", 4'hF, 4'h0, 1'b1);
    @(posedge CLK); #1;

    // Reset mid-BUBBLE returns to RUN with no leftover bubbles.
    apply(8'h82);
    @(posedge CLK); #1;
    apply(8'h80);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk_comb("bubble_reset", 4'hF, 4'h0, 1'b1);
    @(posedge CLK); #1;

    // Stall counter saturation: 2^CNT_W+5 dmem-wait cycles.
    do_reset();
    apply(8'hC0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      @(posedge CLK); #1;
    end
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd15);
    apply(8'h80);
    @(posedge CLK); #1;
    chk("sat.stall_cnt_hold", 32'(stall_cnt), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
